// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle (shift-add / restoring).
// Define MULDIV_EARLY_OUT_EN to finish divide-by-zero, signed overflow and zero-operand multiplies in one cycle.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Result
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state;
    logic [2:0] op;
    logic neg;
    logic [CW-1:0] cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0] opnd;
    logic a_sgn, b_sgn, neg_a, neg_b, b_zero, ovf, mul_zero, early, sign_in;
    logic [W-1:0] mag_a, mag_b, early_res, fix_res, q_or_r;
    logic [W:0] mul_sum, rem_sh, diff;
    logic [2*W-1:0] mul_next, div_next, prod;
    always_comb begin
        a_sgn = Funct3 == 3'b001 || Funct3 == 3'b010 || Funct3 == 3'b100 || Funct3 == 3'b110;
        b_sgn = Funct3 == 3'b001 || Funct3 == 3'b100 || Funct3 == 3'b110;
        neg_a = a_sgn & SrcA[W-1];
        neg_b = b_sgn & SrcB[W-1];
        mag_a = neg_a ? -SrcA : SrcA;
        mag_b = neg_b ? -SrcB : SrcB;
        b_zero = SrcB == '0;
        // remainder follows the dividend; a zero divisor yields an all-ones quotient, never negated
        sign_in = (Funct3[2] & Funct3[1]) ? neg_a : (neg_a ^ neg_b) & ~(Funct3[2] & b_zero);
        ovf = Funct3[2] & ~Funct3[0] & (SrcA == {1'b1, {(W-1){1'b0}}}) & (SrcB == '1);
        mul_zero = ~Funct3[2] & ((SrcA == '0) | b_zero);
        early = EARLY_OUT & ((Funct3[2] & b_zero) | ovf | mul_zero);
        early_res = mul_zero ? '0 : b_zero ? (Funct3[1] ? SrcA : '1) : (Funct3[1] ? '0 : SrcA);
    end
    always_comb begin
        mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[W-1:1]};
        rem_sh = acc[2*W-1:W-1];
        diff = rem_sh - {1'b0, opnd};
        div_next = diff[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0} : {diff[W-1:0], acc[W-2:0], 1'b1};
        prod = neg ? -acc : acc;
        q_or_r = op[1] ? acc[2*W-1:W] : acc[W-1:0];
        fix_res = op[2] ? (neg ? -q_or_r : q_or_r) : (op[1:0] == 2'b00 ? prod[W-1:0] : prod[2*W-1:W]);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            Result <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op <= Funct3;
                        neg <= sign_in;
                        cnt <= CW'(W);
                        acc <= {{W{1'b0}}, Funct3[2] ? mag_a : mag_b};
                        opnd <= Funct3[2] ? mag_b : mag_a;
                        if (early) begin
                            Result <= early_res;
                            state <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy <= 1'b1;
                            done <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy <= 1'b0;
                        done <= 1'b0;
                    end
                end
                CALC: begin
                    acc <= op[2] ? div_next : mul_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    Result <= fix_res;
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset, start;
    logic [2:0] Funct3;
    logic [31:0] SrcA, SrcB;
    logic busy, done;
    logic [31:0] Result;
    int n_cmp = 0;
    int n_bad = 0;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    always #5 clk = ~clk;
    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .Result(Result)
    );
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub, p;
        int ia, ib;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: return a * b;
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction
    function automatic bit is_trivial(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) return b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
        return a == 0 || b == 0;
    endfunction
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input string nm);
        int exp_lat, cyc;
        bit busy_ok;
        exp_lat = (EARLY && is_trivial(f, a, b)) ? 1 : 34;
        @(negedge clk);
        Funct3 = f;
        SrcA = a;
        SrcB = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc != exp_lat) begin
            n_bad++;
            $display("FAIL %s latency f=%0d a=%h b=%h: got %0d expected %0d", nm, f, a, b, cyc, exp_lat);
        end
        n_cmp++;
        if (Result !== exp_res) begin
            n_bad++;
            $display("FAIL %s result f=%0d a=%h b=%h: got %h expected %h", nm, f, a, b, Result, exp_res);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy in done cycle: got %b expected 0", nm, busy);
        end
        n_cmp++;
        if (busy_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy before done: got low expected high", nm);
        end
    endtask
    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        Funct3 = 3'd0;
        SrcA = 32'h0;
        SrcB = 32'h0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b expected 0", done); end
        n_cmp++;
        if (Result !== 32'h0) begin n_bad++; $display("FAIL reset Result: got %h expected 0", Result); end
        reset = 1'b0;
    endtask
    task automatic test_directed();
        do_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
        do_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
        do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
        do_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div");
        do_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem");
        do_op(3'd5, 32'd100, 32'd7, 32'd14, "divu");
        do_op(3'd7, 32'd100, 32'd7, 32'd2, "remu");
        do_op(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, "div_by_zero");
        do_op(3'd6, 32'd5, 32'd0, 32'd5, "rem_by_zero");
        do_op(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by_zero");
        do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_overflow");
        do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_overflow");
        do_op(3'd0, 32'h0, 32'd5, 32'h0, "mul_zero");
        do_op(3'd1, 32'hFFFFFFFF, 32'h0, 32'h0, "mulh_zero");
    endtask
    task automatic test_random();
        logic [2:0] f;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 32'h0;
                1: a = 32'h80000000;
                2: a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            do_op(f, a, b, ref_model(f, a, b), "random");
        end
    endtask
    task automatic test_ignore_start();
        int cyc;
        @(negedge clk);
        Funct3 = 3'd5;
        SrcA = 32'd100;
        SrcB = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            start = (cyc == 5 || cyc == 10);
            Funct3 = start ? 3'd0 : 3'd5;
            SrcA = start ? 32'd1 : 32'd100;
            SrcB = start ? 32'd0 : 32'd7;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        n_cmp++;
        if (cyc != 34) begin n_bad++; $display("FAIL ignore_start latency: got %0d expected 34", cyc); end
        n_cmp++;
        if (Result !== 32'd14) begin n_bad++; $display("FAIL ignore_start result: got %h expected 0000000e", Result); end
    endtask
    task automatic test_back_to_back();
        int cyc;
        bit hold_ok;
        do_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "b2b_first");
        Funct3 = 3'd5;
        SrcA = 32'd100;
        SrcB = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        hold_ok = 1'b1;
        while (done !== 1'b1 && cyc < 100) begin
            if (Result !== 32'hFFFFFFEB) hold_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc != 34) begin n_bad++; $display("FAIL b2b latency: got %0d expected 34", cyc); end
        n_cmp++;
        if (Result !== 32'd14) begin n_bad++; $display("FAIL b2b result: got %h expected 0000000e", Result); end
        n_cmp++;
        if (hold_ok !== 1'b1) begin n_bad++; $display("FAIL b2b hold: Result changed before done, expected ffffffeb held"); end
    endtask
    task automatic test_reset_abort();
        bit seen;
        do_op(3'd5, 32'd100, 32'd7, 32'd14, "abort_setup");
        @(negedge clk);
        Funct3 = 3'd5;
        SrcA = 32'hFFFFFFFF;
        SrcB = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort busy: got %b expected 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL abort done: got %b expected 0", done); end
        n_cmp++;
        if (Result !== 32'h0) begin n_bad++; $display("FAIL abort Result: got %h expected 0", Result); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL abort activity: got done/busy after reset expected none"); end
        do_op(3'd7, 32'd100, 32'd7, 32'd2, "after_abort");
    endtask
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit implementing the RV32M operations alongside the single-cycle ALU in the execute stage. It latches operands and a funct3 opcode on a start pulse, iterates one bit per cycle (shift-add multiply, restoring divide), and returns a DATA_WIDTH result with a one-cycle done pulse. The hazard logic stalls the pipeline while busy is high.

## Interface

- DATA_WIDTH, 32, operand and result width.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- Funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  DATA_WIDTH  rs1 operand (multiplicand / dividend).
- SrcB  input  DATA_WIDTH  rs2 operand (multiplier / divisor).
- busy  output  1  high in CALC and FIX.
- done  output  1  one-cycle pulse; Result valid in that cycle.
- Result  output  DATA_WIDTH  result; held from the done cycle until the next accepted start completes.

## Operation

- States: IDLE, CALC, FIX, DONE. Reset -> IDLE, busy=0, done=0, Result=0, counter=0.
- IDLE or DONE with start=1: latch Funct3, SrcA, SrcB.
  - Compute operand magnitudes: signed for MULH and DIV/REM; SrcA only for MULHSU; none for U variants and MUL.
  - Record the result sign.
  - Load counter=DATA_WIDTH and go to CALC.
- IDLE or DONE with start=0: go to (or remain in) IDLE.
- CALC: one iteration per cycle and counter decrements. Go to FIX when counter reaches 1.
  - Multiply: 2*DATA_WIDTH-bit accumulator; add the multiplicand if the multiplier LSB=1, then shift right.
  - Divide: shift the remainder/quotient pair left, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
- FIX: apply two's-complement negation if the sign flag is set, then select the result:
  - MUL: low DATA_WIDTH bits.
  - MULH/MULHSU/MULHU: high DATA_WIDTH bits of the signed-corrected product.
  - DIV/DIVU: quotient. REM/REMU: remainder, which takes the dividend's sign.
  - Register Result and go to DONE.
- DONE: done=1 for exactly this cycle.
- Division corner cases follow the RISC-V M specification:
  - Divide by zero: quotient = all ones; remainder = SrcA.
  - Signed overflow (SrcA = 0x80000000, SrcB = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- start while busy=1 is ignored; latched operands are unaffected.
- Reset asserted in any state aborts the operation next edge: IDLE, busy=0, done=0, Result=0. No done pulse is produced for the aborted operation.

## Timing

- Start accepted at edge 0. CALC occupies cycles 1..DATA_WIDTH; FIX occupies cycle DATA_WIDTH+1.
- done=1 and Result valid in cycle DATA_WIDTH+2 (34 for DATA_WIDTH=32).
- busy is high in cycles 1..DATA_WIDTH+1 and low in the done cycle.
- Back-to-back: start may be asserted in the done cycle. The next operation then begins with no idle bubble, and Result holds its old value until the new done.
- busy and done are registered outputs (pure functions of state); Result is registered.

## Configuration

- MULDIV_EARLY_OUT_EN defined: three cases bypass CALC and FIX and go IDLE/DONE -> DONE directly, with done asserted in cycle 1 and busy never asserted.
  - Divide by zero.
  - Signed-division overflow.
  - Any multiply with SrcA=0 or SrcB=0.
- MULDIV_EARLY_OUT_EN undefined: every operation takes the full DATA_WIDTH+2 cycles.
- Result values are identical in both builds; only latency differs.

## Test plan

- MUL, SrcA=7, SrcB=-3 (0xFFFFFFFD) -> Result=0xFFFFFFEB; done at cycle 34; busy high cycles 1..33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000. Latency is 1 cycle with MULDIV_EARLY_OUT_EN, 34 cycles without.
- start pulses at cycles 5 and 10 during an operation are ignored, and the original result is returned. A new start in the done cycle yields a second done exactly 34 cycles later.
- reset asserted at cycle 12 of a DIVU -> next cycle busy=0, done=0, Result=0, and no done pulse follows.
